// File: rtl/perf_pkg.sv
// Shared types for the BCD performance monitor: FSM states and BCD digit type.
package perf_pkg;
    typedef enum logic [1:0] {IDLE, RUNNING, DONE} perf_state_t;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_NINE = 4'd9;
endpackage

// File: rtl/perf_monitor_if.sv
// Host-side bus of the performance monitor: window control, event strobes and digit readout.
interface perf_monitor_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_DIGITS   = 8,
    parameter int PC_WIDTH     = 12
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    clear;
    logic [PC_WIDTH-1:0]     pc;
    logic [NUM_CHANNELS-1:0] event_in;
    logic [NUM_CHANNELS-1:0] chan_en;
    logic [CW-1:0]           rd_chan;
    logic [DW-1:0]           rd_digit;
    logic [3:0]              rd_value;
    logic [NUM_CHANNELS-1:0] saturated;
    logic                    running;
    logic                    finished;

    modport master (
        output clear, pc, event_in, chan_en, rd_chan, rd_digit,
        input  rd_value, saturated, running, finished
    );
    modport slave (
        input  clear, pc, event_in, chan_en, rd_chan, rd_digit,
        output rd_value, saturated, running, finished
    );
endinterface

// File: rtl/perf_monitor_bcd_counter.sv
// One BCD event channel: single-cycle ripple-carry increment with sticky saturation at all 9s.
module bcd_counter
    import perf_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                        CLK_50,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        inc,
    output bcd_digit_t [NUM_DIGITS-1:0] digits,
    output logic                        sat
);
    bcd_digit_t [NUM_DIGITS-1:0] digits_q, digits_d;
    logic sat_q, sat_d;
    logic all_nine, carry;

    always_comb begin
        digits_d = digits_q;
        sat_d    = sat_q;
        all_nine = 1'b1;
        carry    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (digits_q[i] != BCD_NINE) all_nine = 1'b0;
        if (clr) begin
            digits_d = '0;
            sat_d    = 1'b0;
        end else if (inc) begin
            if (all_nine) begin
                sat_d = 1'b1;
            end else begin
                // Decimal carry ripples through every digit within this edge.
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (carry) begin
                        if (digits_q[i] == BCD_NINE) begin
                            digits_d[i] = '0;
                        end else begin
                            digits_d[i] = digits_q[i] + 4'd1;
                            carry       = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            sat_q    <= sat_d;
        end
    end

    assign digits = digits_q;
    assign sat    = sat_q;
endmodule

// File: rtl/perf_monitor.sv
// Multi-channel BCD performance monitor: PC-windowed start/stop FSM, gated BCD channels, registered digit readout.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int                  NUM_CHANNELS = 4,
    parameter int                  NUM_DIGITS   = 8,
    parameter int                  PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0] START_PC     = '0,
    parameter logic [PC_WIDTH-1:0] FINAL_PC     = {PC_WIDTH{1'b1}}
) (
    input logic           CLK_50,
    input logic           reset,
    perf_monitor_if.slave bus
);
    perf_state_t state_q, state_d;
    logic        running_q, finished_q;
    bcd_digit_t  rd_value_q, rd_value_d;

    bcd_digit_t [NUM_CHANNELS-1:0][NUM_DIGITS-1:0] digits;
    logic [NUM_CHANNELS-1:0] sat, inc;

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (bus.pc == START_PC) state_d = RUNNING;
                RUNNING: if (bus.pc == FINAL_PC) state_d = DONE;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Flags are registered from the next state so they track state_q with no extra lag.
    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
            rd_value_q <= '0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == RUNNING);
            finished_q <= (state_d == DONE);
            rd_value_q <= rd_value_d;
        end
    end

    assign inc = {NUM_CHANNELS{state_q == RUNNING}} & bus.event_in & bus.chan_en & ~sat;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        bcd_counter #(.NUM_DIGITS(NUM_DIGITS)) u_cnt (
            .CLK_50 (CLK_50),
            .reset  (reset),
            .clr    (bus.clear),
            .inc    (inc[g]),
            .digits (digits[g]),
            .sat    (sat[g])
        );
    end

    always_comb begin
        rd_value_d = '0;
        if (int'(bus.rd_chan) < NUM_CHANNELS && int'(bus.rd_digit) < NUM_DIGITS)
            rd_value_d = digits[bus.rd_chan][bus.rd_digit];
    end

    assign bus.rd_value  = rd_value_q;
    assign bus.saturated = sat;
    assign bus.running   = running_q;
    assign bus.finished  = finished_q;
endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: 8-digit instance for window/count/readout, 2-digit instance for saturation.
module tb_perf_monitor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perf_monitor_if #(.NUM_CHANNELS(4), .NUM_DIGITS(8), .PC_WIDTH(12)) ba ();
    perf_monitor_if #(.NUM_CHANNELS(4), .NUM_DIGITS(2), .PC_WIDTH(12)) bb ();

    perf_monitor #(.NUM_CHANNELS(4), .NUM_DIGITS(8), .PC_WIDTH(12)) dut_a (
        .CLK_50(clk), .reset(rst), .bus(ba));
    perf_monitor #(.NUM_CHANNELS(4), .NUM_DIGITS(2), .PC_WIDTH(12)) dut_b (
        .CLK_50(clk), .reset(rst), .bus(bb));

    int n_tests = 0;
    int n_fail  = 0;
    int qa[$];
    int qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dig(input int v, input int d);
        int x = v;
        for (int i = 0; i < d; i++) x = x / 10;
        return x % 10;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input int ch, input int dg, input int exp, input string tag);
        ba.rd_chan  = 2'(ch);
        ba.rd_digit = 3'(dg);
        qa.push_back(exp);
        step();
        chk(tag, 32'(ba.rd_value), qa.pop_front());
    endtask

    task automatic rd_b(input int ch, input int dg, input int exp, input string tag);
        bb.rd_chan  = 2'(ch);
        bb.rd_digit = 1'(dg);
        qb.push_back(exp);
        step();
        chk(tag, 32'(bb.rd_value), qb.pop_front());
    endtask

    task automatic read_a_val(input int ch, input int val, input string tag);
        for (int d = 0; d < 8; d++) rd_a(ch, d, dig(val, d), tag);
    endtask

    initial begin
        ba.clear = 0; ba.pc = 12'd100; ba.event_in = '0; ba.chan_en = 4'hF;
        ba.rd_chan = '0; ba.rd_digit = '0;
        bb.clear = 0; bb.pc = 12'd100; bb.event_in = '0; bb.chan_en = 4'hF;
        bb.rd_chan = '0; bb.rd_digit = '0;
        rst = 1'b1;
        repeat (2) step();
        chk("rst_running", 32'(ba.running), 0);
        chk("rst_finished", 32'(ba.finished), 0);
        chk("rst_sat", 32'(ba.saturated), 0);
        chk("rst_rdval", 32'(ba.rd_value), 0);
        rst = 1'b0;

        // Test 1: pc=START_PC edge arms (not counted), pc=1..9 gives 9, FINAL_PC edge counted -> 10.
        ba.event_in = 4'b0001;
        step();
        chk("t1_idle", 32'(ba.running), 0);
        ba.pc = 12'd0;
        step();
        chk("t1_running", 32'(ba.running), 1);
        for (int p = 1; p <= 9; p++) begin
            ba.pc = 12'(p);
            step();
        end
        ba.pc = 12'hFFF;
        step();
        chk("t1_finished", 32'(ba.finished), 1);
        chk("t1_not_running", 32'(ba.running), 0);
        ba.pc = 12'd5;
        step();
        chk("t1_done_holds", 32'(ba.finished), 1);
        ba.event_in = '0;
        read_a_val(0, 10, "t1_ch0");

        // Test 2: 1000 events on channel 1 -> carry through three digits.
        ba.clear = 1; step(); ba.clear = 0;
        chk("t2_cleared", 32'(ba.finished), 0);
        ba.pc = 12'd0; step();
        ba.pc = 12'd1; ba.event_in = 4'b0010;
        repeat (1000) step();
        ba.event_in = '0;
        read_a_val(1, 1000, "t2_ch1");
        rd_a(0, 0, 0, "t2_ch0");
        chk("t2_running", 32'(ba.running), 1);

        // Test 4: channel mask 0101, readout of ch0 digit0 during counting shows pre-increment value.
        ba.clear = 1; step(); ba.clear = 0;
        ba.chan_en = 4'b0101; ba.event_in = 4'hF; ba.pc = 12'd0;
        step();
        ba.pc = 12'd1;
        for (int k = 0; k < 20; k++) rd_a(0, 0, k % 10, "t4_pre_inc");
        ba.event_in = '0;
        read_a_val(0, 20, "t4_ch0");
        read_a_val(1, 0, "t4_ch1");
        read_a_val(2, 20, "t4_ch2");
        read_a_val(3, 0, "t4_ch3");
        ba.chan_en = 4'hF;

        // Test 5: clear together with FINAL_PC while running wins.
        ba.pc = 12'hFFF; ba.clear = 1; ba.event_in = 4'hF;
        step();
        ba.clear = 0; ba.pc = 12'd5;
        chk("t5_running", 32'(ba.running), 0);
        chk("t5_finished", 32'(ba.finished), 0);
        step();
        chk("t5_finished_stays", 32'(ba.finished), 0);
        ba.event_in = '0;
        read_a_val(0, 0, "t5_ch0");
        read_a_val(2, 0, "t5_ch2");

        // Test 3: 2-digit build saturates at 99 on the 100th event.
        bb.pc = 12'd0; step();
        bb.pc = 12'd1; bb.event_in = 4'b0100;
        for (int k = 1; k <= 105; k++) begin
            step();
            chk("t3_sat_step", 32'(bb.saturated[2]), (k >= 100) ? 1 : 0);
        end
        bb.event_in = '0;
        rd_b(2, 0, 9, "t3_d0");
        rd_b(2, 1, 9, "t3_d1");
        chk("t3_sat_vec", 32'(bb.saturated), 32'h4);
        rd_b(0, 0, 0, "t3_ch0");

        // Test 6: async reset between edges during RUNNING.
        ba.pc = 12'd0; step();
        ba.pc = 12'd1; ba.event_in = 4'b0001;
        for (int k = 0; k < 5; k++) rd_a(0, 0, k, "t6_pre");
        chk("t6_rd_before", 32'(ba.rd_value), 4);
        #2 rst = 1'b1;
        #1;
        chk("t6_running", 32'(ba.running), 0);
        chk("t6_rdval", 32'(ba.rd_value), 0);
        chk("t6_b_running", 32'(bb.running), 0);
        chk("t6_b_sat", 32'(bb.saturated), 0);
        #1 rst = 1'b0;
        ba.event_in = '0; ba.pc = 12'd0;
        step();
        chk("t6_restart", 32'(ba.running), 1);
        ba.pc = 12'd1; ba.event_in = 4'b0001;
        repeat (3) step();
        ba.event_in = '0;
        read_a_val(0, 3, "t6_ch0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
